trail_writer: RTL and testbench

TRAIL_WRITER -- requirements
Module: trail_writer

---
 rtl/trail_writer.sv | 132 +++++++++++++
 tb/tb_trail_writer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/trail_writer.sv
// trail_writer: clears a 320x480-word frame buffer and writes one trail word per bike on each synchronised frame tick (define TRAIL_THICK_EN to add a companion write at row Y+1)
module trail_writer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        Enable,
  input  logic        Clear_Req,
  input  logic [9:0]  Blue_X,
  input  logic [9:0]  Blue_Y,
  input  logic [9:0]  Red_X,
  input  logic [9:0]  Red_Y,
  output logic        WE,
  output logic [18:0] write_address,
  output logic [15:0] Data_In,
  output logic        Busy,
  output logic        Clear_Done
);
`ifdef TRAIL_THICK_EN
  typedef enum logic [2:0] {CLEAR, IDLE, WR_BLUE, WR_BLUE2, WR_RED, WR_RED2} state_t;
`else
  typedef enum logic [1:0] {CLEAR, IDLE, WR_BLUE, WR_RED} state_t;
`endif
  localparam logic [18:0] WORDS = 19'd153600;
  localparam logic [15:0] BG = 16'h0808;
  localparam logic [15:0] BLUE = 16'h0101;
  localparam logic [15:0] RED = 16'h0202;
  state_t state_q, state_d;
  logic [18:0] clr_q, clr_d;
  logic [9:0] bx_q, bx_d, by_q, by_d, rx_q, rx_d, ry_q, ry_d;
  logic s1_q, s2_q, s3_q, tick;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic red, comp, bike;
  logic [9:0] px;
  logic [10:0] py;
  assign tick = s2_q & ~s3_q;
  assign WE = we_q;
  assign write_address = addr_q;
  assign Data_In = data_q;
  assign Busy = busy_q;
  assign Clear_Done = done_q;
  always_comb begin
    state_d = state_q;
    clr_d = clr_q;
    bx_d = bx_q;
    by_d = by_q;
    rx_d = rx_q;
    ry_d = ry_q;
    we_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    done_d = 1'b0;
    if (Clear_Req) begin
      state_d = CLEAR;
      clr_d = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_q == WORDS) begin
            state_d = IDLE;
            done_d = 1'b1;
          end else begin
            we_d = 1'b1;
            addr_d = clr_q;
            data_d = BG;
            clr_d = clr_q + 19'd1;
          end
        end
        IDLE: begin
          if (tick && Enable) begin
            state_d = WR_BLUE;
            bx_d = Blue_X;
            by_d = Blue_Y;
            rx_d = Red_X;
            ry_d = Red_Y;
          end
        end
`ifdef TRAIL_THICK_EN
        WR_BLUE: state_d = WR_BLUE2;
        WR_BLUE2: state_d = WR_RED;
        WR_RED: state_d = WR_RED2;
`else
        WR_BLUE: state_d = WR_RED;
`endif
        default: state_d = IDLE;
      endcase
    end
    // The registered write belongs to the state being entered, so the blue
    // write appears in the same cycle the block sits in WR_BLUE.
`ifdef TRAIL_THICK_EN
    red = state_d == WR_RED || state_d == WR_RED2;
    comp = state_d == WR_BLUE2 || state_d == WR_RED2;
    bike = red || comp || state_d == WR_BLUE;
`else
    red = state_d == WR_RED;
    comp = 1'b0;
    bike = red || state_d == WR_BLUE;
`endif
    px = red ? rx_d : bx_d;
    py = {1'b0, red ? ry_d : by_d} + {10'd0, comp};
    if (bike && px < 10'd640 && py < 11'd480) begin
      we_d = 1'b1;
      addr_d = {10'd0, px[9:1]} + ({8'd0, py} << 8) + ({8'd0, py} << 6);
      data_d = red ? RED : BLUE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= CLEAR;
      clr_q <= '0;
      {bx_q, by_q, rx_q, ry_q} <= '0;
      {s1_q, s2_q, s3_q} <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      {bx_q, by_q, rx_q, ry_q} <= {bx_d, by_d, rx_d, ry_d};
      {s1_q, s2_q, s3_q} <= {frame_clk, s1_q, s2_q};
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_trail_writer.sv
// tb_trail_writer: directed self-checking bench for trail_writer
module tb_trail_writer;
  logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, Enable = 1'b0, Clear_Req = 1'b0;
  logic [9:0] Blue_X = '0, Blue_Y = '0, Red_X = '0, Red_Y = '0;
  logic WE, Busy, Clear_Done;
  logic [18:0] write_address;
  logic [15:0] Data_In;
  int total = 0, passed = 0, failed = 0;
  trail_writer dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Enable(Enable), .Clear_Req(Clear_Req),
    .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
    .WE(WE), .write_address(write_address), .Data_In(Data_In), .Busy(Busy), .Clear_Done(Clear_Done)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic wr(input string tag, input logic [18:0] a, input logic [15:0] d);
    step();
    chk({tag, "_we"}, WE, 1);
    chk({tag, "_addr"}, write_address, a);
    chk({tag, "_data"}, Data_In, d);
    chk({tag, "_busy"}, Busy, 1);
  endtask
  task automatic skip(input string tag);
    step();
    chk({tag, "_we"}, WE, 0);
    chk({tag, "_busy"}, Busy, 1);
  endtask
  task automatic done(input string tag);
    step();
    chk({tag, "_we"}, WE, 0);
    chk({tag, "_busy"}, Busy, 0);
  endtask
  task automatic start_tick(input string tag);
    frame_clk = 1'b1;
    step();
    chk({tag, "_pre0"}, WE, 0);
    step();
    chk({tag, "_pre1"}, WE, 0);
    frame_clk = 1'b0;
  endtask
  task automatic idle(input string tag, input int n);
    int w = 0, b = 0;
    repeat (n) begin
      step();
      if (WE !== 1'b0) w++;
      if (Busy !== 1'b0) b++;
    end
    chk({tag, "_we_cycles"}, w, 0);
    chk({tag, "_busy_cycles"}, b, 0);
  endtask
  task automatic sweep(input string tag);
    int n = 0, bad = 0, cyc = 0;
    bit fin = 0;
    logic [18:0] ea = '0;
    while (!fin && cyc < 160000) begin
      step();
      cyc++;
      if (cyc == 100) frame_clk = 1'b1;
      if (cyc == 104) frame_clk = 1'b0;
      if (Clear_Done === 1'b1) fin = 1;
      else if (WE === 1'b1) begin
        if (write_address !== ea || Data_In !== 16'h0808 || Busy !== 1'b1) bad++;
        ea++;
        n++;
      end else bad++;
    end
    chk({tag, "_done_seen"}, fin, 1);
    chk({tag, "_writes"}, n, 153600);
    chk({tag, "_bad"}, bad, 0);
    chk({tag, "_done_we"}, WE, 0);
    chk({tag, "_done_busy"}, Busy, 0);
    step();
    chk({tag, "_done_pulse"}, Clear_Done, 0);
  endtask
  initial begin
    step();
    step();
    chk("rst_we", WE, 0);
    chk("rst_addr", write_address, 0);
    chk("rst_data", Data_In, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Clear_Done, 0);
    Reset = 1'b0;
    sweep("sweep_rst");
    idle("idle_rst", 8);
    Enable = 1'b1;
    Blue_X = 10'd100; Blue_Y = 10'd50; Red_X = 10'd641; Red_Y = 10'd10;
    start_tick("t1");
    wr("t1_blue", 19'd16050, 16'h0101);
    Red_X = 10'd0; Red_Y = 10'd0;
`ifdef TRAIL_THICK_EN
    wr("t1_blue2", 19'd16370, 16'h0101);
    skip("t1_red");
    skip("t1_red2");
`else
    skip("t1_red");
    chk("t1_hold_addr", write_address, 19'd16050);
    chk("t1_hold_data", Data_In, 16'h0101);
`endif
    done("t1_end");
    idle("t1_idle", 4);
    Blue_X = 10'd639; Blue_Y = 10'd479; Red_X = 10'd0; Red_Y = 10'd0;
    start_tick("t2");
    wr("t2_blue", 19'd153599, 16'h0101);
`ifdef TRAIL_THICK_EN
    skip("t2_blue2");
    wr("t2_red", 19'd0, 16'h0202);
    wr("t2_red2", 19'd320, 16'h0202);
`else
    wr("t2_red", 19'd0, 16'h0202);
`endif
    done("t2_end");
    idle("t2_idle", 4);
    Blue_X = 10'd10; Blue_Y = 10'd479; Red_X = 10'd10; Red_Y = 10'd0;
    start_tick("t3");
    wr("t3_blue", 19'd153285, 16'h0101);
`ifdef TRAIL_THICK_EN
    skip("t3_blue2");
    wr("t3_red", 19'd5, 16'h0202);
    wr("t3_red2", 19'd325, 16'h0202);
`else
    wr("t3_red", 19'd5, 16'h0202);
`endif
    done("t3_end");
    idle("t3_idle", 4);
    Enable = 1'b0;
    start_tick("dis");
    idle("dis_idle", 6);
    Enable = 1'b1;
    Blue_X = 10'd2; Blue_Y = 10'd0; Red_X = 10'd4; Red_Y = 10'd0;
    start_tick("cr");
    wr("cr_blue", 19'd1, 16'h0101);
    Clear_Req = 1'b1;
    step();
    chk("cr_abort_we", WE, 0);
    chk("cr_abort_busy", Busy, 1);
    chk("cr_abort_done", Clear_Done, 0);
    Clear_Req = 1'b0;
    sweep("sweep_cr");
    idle("idle_cr", 8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
